// File: rtl/seq_divider_16bits_if.sv
// Handshake and operand/result bundle for seq_divider_16bits.
// master drives requests (datapath control), slave is the divider.
interface seq_divider_16bits_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_divider_16bits.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division); unsigned otherwise.
module seq_divider_16bits #(
    parameter int unsigned WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    seq_divider_16bits_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              div_zero_q, div_zero_d;

    logic [WIDTH:0]    trial;
    logic [WIDTH:0]    diff;
    logic              borrow;
    logic [WIDTH-1:0]  rem_step;
    logic [WIDTH-1:0]  q_step;
    logic [WIDTH-1:0]  q_res;
    logic [WIDTH-1:0]  r_res;
    logic [WIDTH-1:0]  dvd_mag;
    logic [WIDTH-1:0]  dvs_mag;

    // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        trial    = {rem_q, q_q[WIDTH-1]};
        diff     = trial - {1'b0, divisor_q};
        borrow   = diff[WIDTH];
        rem_step = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        q_step   = {q_q[WIDTH-2:0], ~borrow};
    end

`ifdef DIV_SIGNED_EN
    logic q_neg_q, q_neg_d;
    logic r_neg_q, r_neg_d;

    assign dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + WIDTH'(1))  : bus.divisor;
    // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1) negates onto itself.
    assign q_res   = q_neg_q ? (~q_step + WIDTH'(1))   : q_step;
    assign r_res   = r_neg_q ? (~rem_step + WIDTH'(1)) : rem_step;
`else
    assign dvd_mag = bus.dividend;
    assign dvs_mag = bus.divisor;
    assign q_res   = q_step;
    assign r_res   = rem_step;
`endif

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
`ifdef DIV_SIGNED_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    divisor_d = dvs_mag;
`ifdef DIV_SIGNED_EN
                    q_neg_d   = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    r_neg_d   = bus.dividend[WIDTH-1];
`endif
                    if (bus.divisor == '0) begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        count_d = CntW'(WIDTH - 1);
                        rem_d   = '0;
                        q_d     = dvd_mag;
                    end
                end
            end
            StRun: begin
                rem_d   = rem_step;
                q_d     = q_step;
                count_d = count_q - CntW'(1);
                if (count_q == '0) begin
                    state_d     = StDone;
                    quotient_d  = q_res;
                    remainder_d = r_res;
                    div_zero_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
endmodule
